// File: rtl/sumsq.sv
`default_nettype none
// ============================================================================
// Module      : sumsq
// Description : Sequential sum-of-squares unit, A^2 + B^2, built from two
//               16-step shift-add squarings into a 33-bit accumulator. The
//               result is handed to a downstream square-root stage through
//               REG_OUT plus a one-cycle CHP_OUT start pulse, held back while
//               that stage reports SQ_BUSY.
//               Optional feature macro: SUMSQ_SIGNED_EN. When it is defined,
//               the operands are two's complement and their magnitudes are
//               squared. When it is undefined, the operands are unsigned and
//               REG_OUT saturates to 0xFFFF_FFFF on accumulator overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sumsq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] A_IN,
  input  logic [15:0] B_IN,
  input  logic        SQ_BUSY,
  output logic [31:0] REG_OUT,
  output logic        CHP_OUT,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQ_A = 2'd1,
    S_SQ_B = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [3:0]  c_LAST_STEP = 4'd15;
  localparam logic [31:0] c_SAT_VAL   = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [15:0] r_a_mag;
  logic [15:0] r_b_mag;
  logic [32:0] r_acc;
  logic [3:0]  r_iter;
  logic [31:0] r_reg_out;
  logic        r_chp;
  logic        r_busy;

  logic [15:0] w_a_mag;
  logic [15:0] w_b_mag;
  logic [15:0] w_cur_mag;
  logic [32:0] w_addend;
  logic [31:0] w_result;

`ifdef SUMSQ_SIGNED_EN
  // Magnitude of a two's complement operand; 0x8000 maps onto 32768, which
  // still fits in 16 unsigned bits, so no extra magnitude bit is needed.
  assign w_a_mag  = A_IN[15] ? (~A_IN + 16'd1) : A_IN;
  assign w_b_mag  = B_IN[15] ? (~B_IN + 16'd1) : B_IN;
  // Two squares of at most 32768 sum to at most 0x8000_0000, so bit 32 of
  // the accumulator can never be set here.
  assign w_result = r_acc[31:0];
`else
  assign w_a_mag  = A_IN;
  assign w_b_mag  = B_IN;
  // Two full-scale unsigned squares overflow 32 bits; clamp instead of wrap.
  assign w_result = r_acc[32] ? c_SAT_VAL : r_acc[31:0];
`endif

  // The operand being squared in the current phase; SQ_A squares A, SQ_B B.
  assign w_cur_mag = (r_state == S_SQ_B) ? r_b_mag : r_a_mag;

  // One shift-add step: the multiplicand shifted by the step index, gated by
  // the multiplier bit of the same index (the operand is its own multiplier).
  assign w_addend  = w_cur_mag[r_iter] ? ({17'd0, w_cur_mag} << r_iter) : 33'd0;

  // Control FSM with registered outputs; both squares accumulate in r_acc.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_a_mag   <= 16'd0;
      r_b_mag   <= 16'd0;
      r_acc     <= 33'd0;
      r_iter    <= 4'd0;
      r_reg_out <= 32'd0;
      r_chp     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // The start pulse is only ever one cycle wide.
      r_chp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_acc   <= 33'd0;
            r_iter  <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_SQ_A;
          end
        end
        S_SQ_A: begin
          r_acc  <= r_acc + w_addend;
          r_iter <= r_iter + 4'd1;
          if (r_iter == c_LAST_STEP) begin
            r_state <= S_SQ_B;
          end
        end
        S_SQ_B: begin
          r_acc  <= r_acc + w_addend;
          r_iter <= r_iter + 4'd1;
          if (r_iter == c_LAST_STEP) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Hand over only when the square-root stage can take a new job.
          if (!SQ_BUSY) begin
            r_reg_out <= w_result;
            r_chp     <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign REG_OUT = r_reg_out;
  assign CHP_OUT = r_chp;
  assign BUSY    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sumsq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumsq
// Description : Self-checking bench for sumsq. Stimulus pushes the expected
//               result and issue cycle into a scoreboard queue; a monitor
//               pops and compares on every CHP_OUT pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumsq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [15:0] A_IN = 16'd0;
  logic [15:0] B_IN = 16'd0;
  logic        SQ_BUSY = 1'b0;
  logic [31:0] REG_OUT;
  logic        CHP_OUT;
  logic        BUSY;

  typedef struct {
    logic [31:0] val;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_sqb = 1'b0;

  sumsq dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .A_IN    (A_IN),
    .B_IN    (B_IN),
    .SQ_BUSY (SQ_BUSY),
    .REG_OUT (REG_OUT),
    .CHP_OUT (CHP_OUT),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  // Edge counter: after rising edge n settles, cyc == n.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Issue one START pulse; k returns the accepting edge index.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input int extra, output int k);
    A_IN  = a;
    B_IN  = b;
    START = 1'b1;
    k     = cyc + 1;
    sb.push_back('{exp, k + 33 + extra});
    step(1);
    START = 1'b0;
  endtask

  // Monitor: every CHP_OUT pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (RST) begin
      if (CHP_OUT) begin
        if (sb.size() == 0) begin
          chk("unexpected_chp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("reg_out", REG_OUT, e.val);
          chk("chp_cycle", cyc, e.at);
          chk("chp_vs_sq_busy", {31'd0, prev_sqb}, 32'd0);
        end
      end
    end
    prev_sqb = SQ_BUSY;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int k;
`ifdef SUMSQ_SIGNED_EN
    vecs[0] = '{16'h8000, 16'h8000, 32'h8000_0000};
    vecs[1] = '{16'hFFFD, 16'h0004, 32'd25};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 32'd2};
    vecs[3] = '{16'hFFFF, 16'h0000, 32'd1};
`else
    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFE_0001};
    vecs[2] = '{16'hFFFD, 16'h0004, 32'hFFFA_0019};
    vecs[3] = '{16'h8000, 16'h8000, 32'h8000_0000};
`endif

    // Reset state.
    step(2);
    chk("rst_reg_out", REG_OUT, 32'd0);
    chk("rst_chp", {31'd0, CHP_OUT}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b1;
    step(2);

    // 3,4 -> 25 with exact latency.
    start_op(16'd3, 16'd4, 32'd25, 0, k);
    chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
    step(32);
    chk("busy_k32", {31'd0, BUSY}, 32'd1);
    chk("chp_k32", {31'd0, CHP_OUT}, 32'd0);
    step(1);
    chk("busy_k33", {31'd0, BUSY}, 32'd0);
    chk("chp_k33", {31'd0, CHP_OUT}, 32'd1);
    step(1);
    chk("chp_k34", {31'd0, CHP_OUT}, 32'd0);
    chk("reg_hold", REG_OUT, 32'd25);
    step(2);

    // Boundary vectors.
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].r, 0, k);
      step(35);
    end

    // Downstream busy until edge k+42 -> issue at k+43.
    SQ_BUSY = 1'b1;
    start_op(16'd10, 16'd20, 32'd500, 10, k);
    step(42);
    chk("busy_wait_k42", {31'd0, BUSY}, 32'd1);
    SQ_BUSY = 1'b0;
    step(3);

    // START re-pulsed at k+5 while busy: ignored.
    start_op(16'd5, 16'd12, 32'd169, 0, k);
    step(4);
    A_IN  = 16'd7;
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(33);

    // START held through the CHP_OUT cycle -> accepted at k+34.
    A_IN  = 16'd1;
    B_IN  = 16'd2;
    START = 1'b1;
    k     = cyc + 1;
    sb.push_back('{32'd5, k + 33});
    sb.push_back('{32'd100, k + 34 + 33});
    step(1);
    A_IN = 16'd6;
    B_IN = 16'd8;
    step(34);
    chk("b2b_accept_busy", {31'd0, BUSY}, 32'd1);
    START = 1'b0;
    step(35);

    // Asynchronous reset mid-operation: abort, no pulse afterwards.
    A_IN  = 16'd9;
    B_IN  = 16'd9;
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(10);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_reg_out", REG_OUT, 32'd0);
    chk("arst_busy", {31'd0, BUSY}, 32'd0);
    chk("arst_chp", {31'd0, CHP_OUT}, 32'd0);
    step(2);
    RST = 1'b1;
    step(45);
    chk("arst_still_idle", {31'd0, BUSY}, 32'd0);

    // Normal operation after reset.
    start_op(16'd255, 16'd255, 32'h0001_FC02, 0, k);
    step(35);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 200 && sb.size() > 0; n++) step(1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
